cpu_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_ctrl_decode.sv | 111 +++++++++++
 rtl/cpu_ctrl.sv | 115 +++++++++++
 tb/tb_cpu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
// Holds the opcode map, the ALU function codes (used by both the controller
// and the ALU so the two ends agree), the writeback mux codes and the
// controller state encoding.
package cpu_pkg;

  // Upper opcode nibble; any value with bit 3 clear is an ALU op.
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1001;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_JZ   = 4'b1101;
  localparam logic [3:0] OP_JC   = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_INC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_SHL = 3'b111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_RS  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational output decode for cpu_ctrl.
// Maps the current state, instruction byte and stored flags onto the
// datapath control lines. Every line defaults to 0 in every state.
// Ports:
//   state_i     current controller state (cpu_pkg::state_e encoding)
//   ir_i        instruction byte: [7:4] opcode, [3:2] Rd, [1:0] Rs
//   zf_i, cf_i  stored zero / carry flags
//   hold_i      fetch stall request; forces all outputs to 0 in FETCH
//   alus_o .. halted_o  control outputs, see cpu_ctrl
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [7:0] ir_i,
  input  logic       zf_i,
  input  logic       cf_i,
  input  logic       hold_i,
  output logic [2:0] alus_o,
  output logic [1:0] rs_sel_o,
  output logic [1:0] rd_sel_o,
  output logic       reg_we_o,
  output logic [1:0] wb_sel_o,
  output logic       addr_sel_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       ir_ld_o,
  output logic       pc_inc_o,
  output logic       pc_ld_o,
  output logic       halted_o
);

  logic [3:0] op;
  logic       fetch_stalled;

  assign op            = ir_i[7:4];
  assign fetch_stalled = (state_i == ST_FETCH) && hold_i;

  always_comb begin
    alus_o     = ALU_ADD;
    rs_sel_o   = 2'b00;
    rd_sel_o   = 2'b00;
    reg_we_o   = 1'b0;
    wb_sel_o   = WB_ALU;
    addr_sel_o = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    ir_ld_o    = 1'b0;
    pc_inc_o   = 1'b0;
    pc_ld_o    = 1'b0;
    halted_o   = 1'b0;

    // Register selects follow ir everywhere except IDLE and a stalled FETCH.
    if ((state_i != ST_IDLE) && !fetch_stalled) begin
      rs_sel_o = ir_i[1:0];
      rd_sel_o = ir_i[3:2];
    end

    case (state_i)
      ST_FETCH: begin
        if (!hold_i) begin
          mem_rd_o = 1'b1;
          ir_ld_o  = 1'b1;
          pc_inc_o = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(op)) begin
          alus_o   = ir_i[6:4];
          wb_sel_o = WB_ALU;
          reg_we_o = 1'b1;
        end else if (op == OP_MOV) begin
          wb_sel_o = WB_RS;
          reg_we_o = 1'b1;
        end
      end
      ST_MEM: begin
        case (op)
          OP_LDI: begin
            mem_rd_o = 1'b1;
            wb_sel_o = WB_MEM;
            reg_we_o = 1'b1;
            pc_inc_o = 1'b1;
          end
          OP_LD: begin
            addr_sel_o = 1'b1;
            mem_rd_o   = 1'b1;
            wb_sel_o   = WB_MEM;
            reg_we_o   = 1'b1;
          end
          OP_ST: begin
            addr_sel_o = 1'b1;
            mem_wr_o   = 1'b1;
          end
          OP_JMP, OP_JZ, OP_JC: begin
            if ((op == OP_JMP) || ((op == OP_JZ) && zf_i) || ((op == OP_JC) && cf_i)) begin
              mem_rd_o = 1'b1;
              pc_ld_o  = 1'b1;
            end else begin
              // Not taken: step over the inline target address byte.
              pc_inc_o = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_HALT: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for the 8-bit datapath.
// Holds the state register, the zero/carry flags and next-state logic;
// output decode lives in cpu_ctrl_decode.
// Optional feature macro: CPU_CTRL_STEP_EN adds the `step` input, which
// gates progress out of FETCH (single-step debug).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ir              instruction byte, must be stable until instruction ends
//   z_in, c_in      ALU zero / carry for the current result
//   step            single-step advance (CPU_CTRL_STEP_EN only)
//   alus            ALU function select
//   rs_sel, rd_sel  ALU x / bus register selects; rd_sel is writeback target
//   reg_we, wb_sel  register write enable and writeback source
//   addr_sel        memory address source: 0 PC, 1 Rs
//   mem_rd, mem_wr  memory strobes
//   ir_ld, pc_inc, pc_ld  IR load, PC increment, PC load from memory
//   halted          high while in HALT
//
// state  | meaning
// IDLE   | after reset, all outputs idle
// FETCH  | read mem[PC] into IR, PC++
// DECODE | select EXEC, MEM or HALT from the opcode
// EXEC   | ALU op or MOV writeback; ALU op loads flags
// MEM    | LDI/LD/ST memory access or jump resolution
// HALT   | parked until reset
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       z_in,
  input  logic       c_in,
`ifdef CPU_CTRL_STEP_EN
  input  logic       step,
`endif
  output logic [2:0] alus,
  output logic [1:0] rs_sel,
  output logic [1:0] rd_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       halted
);

  state_e     state_q, state_d;
  logic       zf_q, cf_q;
  logic       fetch_hold;
  logic [3:0] op;

  assign op = ir[7:4];

`ifdef CPU_CTRL_STEP_EN
  assign fetch_hold = ~step;
`else
  assign fetch_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (!fetch_hold) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_alu_op(op) || (op == OP_MOV)) state_d = ST_EXEC;
        else if (op == OP_HALT)              state_d = ST_HALT;
        else                                 state_d = ST_MEM;
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_MEM:    state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_EXEC) && is_alu_op(op)) begin
        zf_q <= z_in;
        cf_q <= c_in;
      end
    end
  end

  cpu_ctrl_decode u_decode (
    .state_i    (state_q),
    .ir_i       (ir),
    .zf_i       (zf_q),
    .cf_i       (cf_q),
    .hold_i     (fetch_hold),
    .alus_o     (alus),
    .rs_sel_o   (rs_sel),
    .rd_sel_o   (rd_sel),
    .reg_we_o   (reg_we),
    .wb_sel_o   (wb_sel),
    .addr_sel_o (addr_sel),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .ir_ld_o    (ir_ld),
    .pc_inc_o   (pc_inc),
    .pc_ld_o    (pc_ld),
    .halted_o   (halted)
  );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl. The stimulus process walks whole
// instructions, pushing the expected control word for every cycle into a
// scoreboard; a monitor on the falling edge pops and compares.
// Build with CPU_CTRL_STEP_EN to also exercise FETCH stalls.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       z_in, c_in;
`ifdef CPU_CTRL_STEP_EN
  logic       step;
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  logic [2:0] alus;
  logic [1:0] rs_sel, rd_sel, wb_sel;
  logic       reg_we, addr_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, halted;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .z_in     (z_in),
    .c_in     (c_in),
`ifdef CPU_CTRL_STEP_EN
    .step     (step),
`endif
    .alus     (alus),
    .rs_sel   (rs_sel),
    .rd_sel   (rd_sel),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .addr_sel (addr_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .ir_ld    (ir_ld),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .halted   (halted)
  );

  logic [16:0] outs;
  assign outs = {alus, rs_sel, rd_sel, reg_we, wb_sel, addr_sel,
                 mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, halted};

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic zf_m, cf_m;   // reference copy of the architectural flags

  // ---------------- reference model: control word per instruction step ----
  function automatic logic [16:0] pk(input logic [2:0] a, input logic [1:0] rs,
                                     input logic [1:0] rd, input logic we,
                                     input logic [1:0] wb, input logic as,
                                     input logic mr, input logic mw,
                                     input logic il, input logic pi,
                                     input logic pl, input logic h);
    return {a, rs, rd, we, wb, as, mr, mw, il, pi, pl, h};
  endfunction

  function automatic logic [16:0] w_fetch(input logic [7:0] i);
    return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 0, 1, 0, 1, 1, 0, 0);
  endfunction

  function automatic logic [16:0] w_decode(input logic [7:0] i);
    return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [16:0] w_exec(input logic [7:0] i);
    if (i[7] == 1'b0) return pk(i[6:4], i[1:0], i[3:2], 1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    return pk(3'd0, i[1:0], i[3:2], 1, 2'd2, 0, 0, 0, 0, 0, 0, 0);   // MOV
  endfunction

  function automatic logic [16:0] w_mem(input logic [7:0] i, input logic zf, input logic cf);
    logic taken;
    case (i[7:4])
      4'h9: return pk(3'd0, i[1:0], i[3:2], 1, 2'd1, 0, 1, 0, 0, 1, 0, 0);
      4'hA: return pk(3'd0, i[1:0], i[3:2], 1, 2'd1, 1, 1, 0, 0, 0, 0, 0);
      4'hB: return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 1, 0, 1, 0, 0, 0, 0);
      default: begin
        taken = (i[7:4] == 4'hC) || ((i[7:4] == 4'hD) && zf) || ((i[7:4] == 4'hE) && cf);
        if (taken) return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 0, 1, 0, 0, 0, 1, 0);
        return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
      end
    endcase
  endfunction

  function automatic logic [16:0] w_halt(input logic [7:0] i);
    return pk(3'd0, i[1:0], i[3:2], 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input string tag, input logic [16:0] e, input logic rst_v,
                     input logic step_v, input logic [7:0] ir_v,
                     input logic z_v, input logic c_v);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = rst_v;
    ir   = ir_v;
    z_in = z_v;
    c_in = c_v;
`ifdef CPU_CTRL_STEP_EN
    step = step_v;
`else
    if (step_v) ;
`endif
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  task automatic run_instr(input logic [7:0] i, input int hold, input bit abort,
                           input logic z, input logic c);
    for (int k = 0; k < hold; k++) cyc("fetch_hold", 17'd0, 0, 0, i, z, c);
    cyc("fetch", w_fetch(i), 0, 1, i, z, c);
    cyc("decode", w_decode(i), 0, 1, i, z, c);
    if (i[7] == 1'b0 || i[7:4] == 4'h8) begin
      cyc("exec", w_exec(i), 0, 1, i, z, c);
      if (i[7] == 1'b0) begin
        zf_m = z;
        cf_m = c;
      end
    end else begin
      cyc("mem", w_mem(i, zf_m, cf_m), abort, 1, i, z, c);
      if (abort) begin
        zf_m = 1'b0;
        cf_m = 1'b0;
        cyc("abort_idle", 17'd0, 0, 1, i, z, c);
      end
    end
  endtask

  task automatic run_halt(input logic [7:0] i, input int n);
    cyc("fetch", w_fetch(i), 0, 1, i, 0, 0);
    cyc("decode", w_decode(i), 0, 1, i, 0, 0);
    for (int k = 0; k < n; k++)
      cyc("halt", w_halt(i), 0, 1, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc("halt_rst", w_halt(i), 1, 1, i, 1, 1);
    zf_m = 1'b0;
    cf_m = 1'b0;
    cyc("halt_idle", 17'd0, 0, 1, i, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t        e;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = outs;
        vectors++;
        if (act !== e.v) begin
          miscompares++;
          $display("FAIL %s @%0t: got %05h expected %05h (ir=%02h)", e.tag, $time, act, e.v, ir);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] i;
    int         hold;
    bit         ab;
    rst  = 1'b1;
    ir   = 8'h00;
    z_in = 1'b0;
    c_in = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    step = 1'b1;
`endif
    zf_m = 1'b0;
    cf_m = 1'b0;

    for (int k = 0; k < 3; k++) cyc("reset", 17'd0, 1, 1, 8'h00, 0, 0);
    cyc("idle", 17'd0, 0, 1, 8'h09, 0, 0);

    // ADD R2,R1 then SHL R1,R1 with both flags set; JZ and JC taken.
    run_instr(8'h09, 0, 0, 0, 1);
    run_instr(8'h75, 0, 0, 1, 1);
    run_instr(8'hD0, 0, 0, 0, 0);
    run_instr(8'hE0, 0, 0, 0, 0);
    // Abort an LDI in MEM: flags must also clear, so JZ/JC fall through.
    run_instr(8'h94, 0, 1, 0, 0);
    run_instr(8'hD0, 0, 0, 1, 1);
    run_instr(8'hE0, 0, 0, 1, 1);
    // ALU result with z=0 then JZ not taken.
    run_instr(8'h2E, 0, 0, 0, 1);
    run_instr(8'hD0, 0, 0, 0, 0);
    run_instr(8'hE3, 0, 0, 0, 0);
    // MOV doesn't touch flags.
    run_instr(8'h8B, 0, 0, 0, 0);
    run_instr(8'hE1, 0, 0, 0, 0);
    // Store, load, jump.
    run_instr(8'hB6, 0, 0, 0, 0);
    run_instr(8'hA7, 0, 0, 0, 0);
    run_instr(8'hC5, 0, 0, 0, 0);
    run_instr(8'h94, 0, 0, 0, 0);
    // Single-step stall of FETCH (no-op when the feature is absent).
    run_instr(8'h1D, STEP_EN ? 3 : 0, 0, 1, 0);
    run_instr(8'hD2, 0, 0, 0, 0);
    // HALT held, then reset restarts.
    run_halt(8'hF0, 12);
    run_instr(8'hD0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        run_halt({4'hF, 4'($urandom_range(0, 15))}, $urandom_range(1, 4));
      end else begin
        i = 8'($urandom_range(0, 255));
        if (i[7:4] == 4'hF) i[7] = 1'b0;
        hold = STEP_EN ? $urandom_range(0, 2) : 0;
        ab   = ($urandom_range(0, 15) == 0);
        run_instr(i, hold, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
